// File: rtl/random_free_column.sv
// Picks a random eligible column from a free mask using a 32-bit xorshift PRNG.
// Draws are rejection-sampled and fall back to a lowest-index scan after MAX_TRIES misses.
module random_free_column #(
  parameter int          NUM_COLS  = 5,
  parameter int          COL_W     = 4,
  parameter int          MAX_TRIES = 8,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [NUM_COLS-1:0] free_mask,
  input  logic                seed_load,
  input  logic [31:0]         seed_in,
  output logic                ready,
  output logic                valid,
  output logic [COL_W-1:0]    columna,
  output logic                none
);

  localparam int         K      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int         CAND_N = 1 << K;
  localparam logic [K:0] NC     = NUM_COLS[K:0];
  localparam logic [7:0] MT     = MAX_TRIES[7:0];

  typedef enum logic [1:0] {IDLE, DRAW, SCAN, DONE} state_t;

  state_t                state_q;
  logic [31:0]           x_q;
  logic [31:0]           x_d;
  logic [7:0]            tries_q;
  logic [NUM_COLS-1:0]   mask_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [COL_W-1:0]      col_q;
  logic                  none_q;

  logic [K-1:0]          cand;
  logic [CAND_N-1:0]     mask_ext;
  logic                  cand_hit;
  logic [COL_W-1:0]      scan_idx;
  logic                  scan_found;

  function automatic logic [31:0] xs_next(input logic [31:0] x);
    logic [31:0] t;
    t = x;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // A zero seed would lock xorshift at zero forever, so it is replaced by SEED.
  always_comb begin
    x_d = xs_next(x_q);
    if (seed_load) begin
      x_d = (seed_in == 32'd0) ? SEED : seed_in;
    end
  end

  assign cand = x_q[K-1:0];

  // Candidates beyond NUM_COLS map onto forced-zero mask bits and are always rejected.
  genvar gi;
  generate
    for (gi = 0; gi < CAND_N; gi++) begin : g_mask_ext
      if (gi < NUM_COLS) begin : g_real
        assign mask_ext[gi] = mask_q[gi];
      end else begin : g_pad
        assign mask_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign cand_hit = ({1'b0, cand} < NC) && mask_ext[cand];

  always_comb begin
    scan_idx   = '0;
    scan_found = 1'b0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        scan_idx   = COL_W'(i);
        scan_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= SEED;
      tries_q <= '0;
      mask_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      col_q   <= '0;
      none_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            mask_q  <= free_mask;
            tries_q <= '0;
            ready_q <= 1'b0;
            // An empty mask takes the one-cycle scan, which reports none with the
            // same latency as a first-draw hit.
            state_q <= (free_mask == '0) ? SCAN : DRAW;
          end
        end
        DRAW: begin
          if (cand_hit) begin
            col_q   <= COL_W'(cand);
            none_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            tries_q <= tries_q + 8'd1;
            if (tries_q == MT - 8'd1) begin
              state_q <= SCAN;
            end
          end
        end
        SCAN: begin
          col_q   <= scan_found ? scan_idx : '0;
          none_q  <= ~scan_found;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign valid   = valid_q;
  assign columna = col_q;
  assign none    = none_q;

endmodule

// File: tb/tb_random_free_column.sv
// Directed and statistical checks of random_free_column against an xorshift reference model.
module tb_random_free_column;

  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [4:0]  mask0 = '0, mask1 = '0;
  logic        sl0 = 1'b0, sl1 = 1'b0;
  logic [31:0] si0 = '0, si1 = '0;
  logic        ready0, valid0, none0, ready1, valid1, none1;
  logic [3:0]  col0, col1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  random_free_column #(.NUM_COLS(5), .COL_W(4), .MAX_TRIES(8), .SEED(SEED)) u_dut0 (
    .clk(clk), .reset(rst), .req(req0), .free_mask(mask0), .seed_load(sl0), .seed_in(si0),
    .ready(ready0), .valid(valid0), .columna(col0), .none(none0)
  );

  random_free_column #(.NUM_COLS(5), .COL_W(4), .MAX_TRIES(1), .SEED(SEED)) u_dut1 (
    .clk(clk), .reset(rst), .req(req1), .free_mask(mask1), .seed_load(sl1), .seed_in(si1),
    .ready(ready1), .valid(valid1), .columna(col1), .none(none1)
  );

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Reference PRNG state, advancing on the same edges as each DUT.
  logic [31:0] m_x0, m_x1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_x0 <= SEED;
      m_x1 <= SEED;
    end else begin
      m_x0 <= sl0 ? ((si0 == 32'd0) ? SEED : si0) : xs(m_x0);
      m_x1 <= sl1 ? ((si1 == 32'd0) ? SEED : si1) : xs(m_x1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // x0 is the state in force on the first DRAW edge; cycle counts from the accept edge = 0.
  task automatic predict(input logic [31:0] x0, input logic [4:0] m, input int mt,
                         output int pcol, output bit pnone, output int pcyc);
    logic [31:0] x;
    int c;
    pcol = 0; pnone = 1'b1; pcyc = 2;
    if (m == 5'd0) return;
    x = x0;
    for (int t = 0; t < mt; t++) begin
      c = int'(x[2:0]);
      if (c < 5 && m[c]) begin
        pcol = c; pnone = 1'b0; pcyc = t + 2;
        return;
      end
      x = xs(x);
    end
    pnone = 1'b0;
    pcyc  = mt + 2;
    for (int i = 4; i >= 0; i--) if (m[i]) pcol = i;
  endtask

  task automatic draw(input bit d1, input logic [4:0] m, input bit disturb,
                      output int cyc, output int col, output bit nn, output bit rdy_after,
                      output int pcol, output bit pnone, output int pcyc);
    if (d1) begin req1 = 1'b1; mask1 = m; end
    else    begin req0 = 1'b1; mask0 = m; end
    @(posedge clk); #1;
    predict(d1 ? m_x1 : m_x0, m, d1 ? 1 : 8, pcol, pnone, pcyc);
    req0 = 1'b0; req1 = 1'b0;
    if (disturb) begin mask0 = ~m; req0 = 1'b1; end
    cyc = 0; col = -1; nn = 1'b0; rdy_after = 1'b0;
    for (int n = 1; n <= 12 && cyc == 0; n++) begin
      @(posedge clk); #1;
      req0 = 1'b0;
      if (d1 ? valid1 : valid0) begin
        cyc = n + 1;
        col = d1 ? int'(col1) : int'(col0);
        nn  = d1 ? none1 : none0;
      end
    end
    if (cyc != 0) begin
      @(posedge clk); #1;
      rdy_after = d1 ? (ready1 && !valid1) : (ready0 && !valid0);
    end
  endtask

  typedef struct {
    logic [4:0] mask;
    bit         disturb;
    int         exp_col;
    bit         exp_none;
    int         min_cyc;
    int         max_cyc;
  } vec_t;

  vec_t vecs[6];
  int   fresh_a[6];
  int   fresh_b[6];

  task automatic fresh_seq(input bit second);
    int cyc, col, pcol, pcyc;
    bit nn, rdy, pnone;
    sl0 = 1'b1; si0 = 32'd0;
    @(posedge clk); #1;
    sl0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      draw(1'b0, 5'b11111, 1'b0, cyc, col, nn, rdy, pcol, pnone, pcyc);
      chk("fresh_col", col, pcol);
      chk("fresh_cyc", cyc, pcyc);
      if (second) fresh_b[i] = col; else fresh_a[i] = col;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, col, pcol, pcyc, seen, scans, bad;
    bit nn, rdy, pnone;
    int tally[5];

    vecs[0] = '{5'b00100, 1'b0, 2, 1'b0, 2, 10};
    vecs[1] = '{5'b00000, 1'b0, 0, 1'b1, 2, 2};
    vecs[2] = '{5'b00001, 1'b0, 0, 1'b0, 2, 10};
    vecs[3] = '{5'b10000, 1'b0, 4, 1'b0, 2, 10};
    vecs[4] = '{5'b01000, 1'b1, 3, 1'b0, 2, 10};
    vecs[5] = '{5'b00010, 1'b1, 1, 1'b0, 2, 10};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready0), 1);
    chk("rst_valid", int'(valid0), 0);
    chk("rst_col", int'(col0), 0);
    chk("rst_none", int'(none0), 0);
    chk("rst_ready1", int'(ready1), 1);
    rst = 1'b0;

    fresh_seq(1'b0);

    foreach (vecs[v]) begin
      draw(1'b0, vecs[v].mask, vecs[v].disturb, cyc, col, nn, rdy, pcol, pnone, pcyc);
      $display("vec %0d mask=%b col=%0d none=%0d cycle=%0d", v, vecs[v].mask, col, nn, cyc);
      chk("vec_col", col, vecs[v].exp_col);
      chk("vec_none", int'(nn), int'(vecs[v].exp_none));
      chk("vec_cyc_model", cyc, pcyc);
      chk("vec_cyc_range", int'(cyc >= vecs[v].min_cyc && cyc <= vecs[v].max_cyc), 1);
      chk("vec_ready_after", int'(rdy), 1);
    end

    // Back-to-back: req held through DONE is re-accepted on the next IDLE cycle.
    req0 = 1'b1; mask0 = 5'b00100;
    @(posedge clk); #1;
    seen = 0;
    for (int n = 0; n < 12 && seen == 0; n++) begin
      @(posedge clk); #1;
      if (valid0) seen = 1;
    end
    chk("b2b_first_valid", seen, 1);
    chk("b2b_first_col", int'(col0), 2);
    @(posedge clk); #1;
    chk("b2b_idle_ready", int'(ready0), 1);
    @(posedge clk); #1;
    chk("b2b_reaccept", int'(ready0), 0);
    req0 = 1'b0;
    seen = 0;
    for (int n = 0; n < 12 && seen == 0; n++) begin
      @(posedge clk); #1;
      if (valid0) seen = 1;
    end
    chk("b2b_second_valid", seen, 1);
    chk("b2b_second_col", int'(col0), 2);
    @(posedge clk); #1;
    $display("back-to-back col=%0d ready=%0d", col0, ready0);

    // Reset while in DRAW aborts the draw without a result.
    req0 = 1'b1; mask0 = 5'b11111;
    @(posedge clk); #1;
    req0 = 1'b0;
    chk("mid_in_draw", int'(ready0), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(valid0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_ready_after_rst", int'(ready0), 1);
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (valid0) seen++;
    end
    chk("mid_no_valid", seen, 0);
    $display("reset mid-draw valid_pulses=%0d", seen);
    fresh_seq(1'b1);
    for (int i = 0; i < 6; i++) chk("fresh_repeat", fresh_b[i], fresh_a[i]);

    // Single eligible column with one try: scan fallback must be taken.
    scans = 0; bad = 0;
    for (int r = 0; r < 1000; r++) begin
      draw(1'b1, 5'b10000, 1'b0, cyc, col, nn, rdy, pcol, pnone, pcyc);
      chk("t1_col", col, 4);
      chk("t1_cyc_model", cyc, pcyc);
      if (cyc == 3) scans++;
    end
    $display("max_tries=1 runs=1000 scan_results=%0d", scans);
    chk("t1_scan_seen", int'(scans > 0), 1);

    // Full mask distribution.
    foreach (tally[i]) tally[i] = 0;
    bad = 0;
    for (int r = 0; r < 10000; r++) begin
      draw(1'b0, 5'b11111, 1'b0, cyc, col, nn, rdy, pcol, pnone, pcyc);
      chk("dist_col_model", col, pcol);
      chk("dist_cyc_model", cyc, pcyc);
      if (col >= 0 && col < 5) tally[col]++;
      else bad++;
    end
    chk("dist_out_of_range", bad, 0);
    for (int i = 0; i < 5; i++) begin
      $display("dist col=%0d count=%0d", i, tally[i]);
      chk("dist_balance", int'(tally[i] >= 1700 && tally[i] <= 2300), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
